pong_game_sequencer: RTL and testbench

Central game-flow controller for the VGA Pong datapath. It converts the raw VGA vertical sync into a per-frame move strobe and owns lives, score and game-over. It sequences the ball datapath through idle, serve-delay, play, miss and game-over phases, driven by the pushbutton controller and by hit/miss pulses from the ball logic. It sits between PB_Controller/VGA_Controller and the ball/bar update logic.

---
 rtl/pong_game_sequencer.sv | 146 ++++++++++++++
 tb/tb_pong_game_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_sequencer.sv
// Game-flow controller for VGA Pong: derives per-frame strobes from VSYNC and sequences
// serve/play/miss/game-over while owning lives, score and the game-over flag.
module pong_game_sequencer #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned SCORE_MAX    = 15,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MISS_FRAMES  = 30
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       VGA_VSYNC,
    input  logic       Start_pushed,
    input  logic       Hit_pulse,
    input  logic       Miss_pulse,
    output logic       Move_enable,
    output logic       Bar_enable,
    output logic       Ball_reset,
    output logic [1:0] Lives,
    output logic [3:0] Score,
    output logic       Game_over,
    output logic [2:0] State
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_MISS  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [1:0] LP_LIVES_INIT = 2'(LIVES_INIT);
    localparam logic [3:0] LP_SCORE_MAX  = 4'(SCORE_MAX);
    localparam logic [7:0] LP_SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] LP_MISS_LAST  = 8'(MISS_FRAMES - 1);

    logic       r_vsync_buf;
    logic [2:0] r_state;
    logic [1:0] r_lives;
    logic [3:0] r_score;
    logic       r_game_over;
    logic [7:0] r_cnt;
    logic       r_ball_reset;

    logic       w_frame_edge;
    logic [2:0] w_state_d;
    logic [1:0] w_lives_d;
    logic [3:0] w_score_d;
    logic       w_game_over_d;
    logic [7:0] w_cnt_d;
    logic       w_ball_reset_d;

    assign w_frame_edge = r_vsync_buf & ~VGA_VSYNC;

    // Strobes are suppressed on a reset cycle so an aborted game emits nothing.
    assign Move_enable = w_frame_edge & ~Reset & (r_state == S_PLAY);
    assign Bar_enable  = w_frame_edge & ~Reset & ((r_state == S_SERVE) | (r_state == S_PLAY));

    assign Ball_reset = r_ball_reset;
    assign Lives      = r_lives;
    assign Score      = r_score;
    assign Game_over  = r_game_over;
    assign State      = r_state;

    always_comb begin
        w_state_d      = r_state;
        w_lives_d      = r_lives;
        w_score_d      = r_score;
        w_game_over_d  = r_game_over;
        w_cnt_d        = r_cnt;
        w_ball_reset_d = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (Start_pushed) begin
                    w_state_d      = S_SERVE;
                    w_lives_d      = LP_LIVES_INIT;
                    w_score_d      = 4'd0;
                    w_game_over_d  = 1'b0;
                    w_cnt_d        = 8'd0;
                    w_ball_reset_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (w_frame_edge) begin
                    if (r_cnt == LP_SERVE_LAST) begin
                        w_state_d = S_PLAY;
                        w_cnt_d   = 8'd0;
                    end else begin
                        w_cnt_d = r_cnt + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // A miss takes priority over a simultaneous hit.
                if (Miss_pulse) begin
                    w_cnt_d = 8'd0;
                    if (r_lives > 2'd1) begin
                        w_lives_d = r_lives - 2'd1;
                        w_state_d = S_MISS;
                    end else begin
                        w_lives_d     = 2'd0;
                        w_game_over_d = 1'b1;
                        w_state_d     = S_OVER;
                    end
                end else if (Hit_pulse && (r_score < LP_SCORE_MAX)) begin
                    w_score_d = r_score + 4'd1;
                end
            end
            S_MISS: begin
                if (w_frame_edge) begin
                    if (r_cnt == LP_MISS_LAST) begin
                        w_state_d      = S_SERVE;
                        w_cnt_d        = 8'd0;
                        w_ball_reset_d = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_d     = S_IDLE;
                w_cnt_d       = 8'd0;
                w_game_over_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_vsync_buf  <= 1'b1;
            r_state      <= S_IDLE;
            r_lives      <= LP_LIVES_INIT;
            r_score      <= 4'd0;
            r_game_over  <= 1'b0;
            r_cnt        <= 8'd0;
            r_ball_reset <= 1'b0;
        end else begin
            r_vsync_buf  <= VGA_VSYNC;
            r_state      <= w_state_d;
            r_lives      <= w_lives_d;
            r_score      <= w_score_d;
            r_game_over  <= w_game_over_d;
            r_cnt        <= w_cnt_d;
            r_ball_reset <= w_ball_reset_d;
        end
    end

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Self-checking bench for pong_game_sequencer: directed game scenarios followed by random
// frames, all checked against a frame-countdown game model.
module tb_pong_game_sequencer;

    localparam int LIVES_INIT   = 3;
    localparam int SCORE_MAX    = 15;
    localparam int SERVE_FRAMES = 60;
    localparam int MISS_FRAMES  = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       start;
    logic       hit;
    logic       miss;
    logic       move_en;
    logic       bar_en;
    logic       ball_rst;
    logic [1:0] lives;
    logic [3:0] score;
    logic       over;
    logic [2:0] state;

    int n_checks = 0;
    int n_err    = 0;
    int n_move   = 0;
    int n_bar    = 0;
    int n_ballr  = 0;

    // Game model: phase uses the published State numbering; frames_left counts down edges.
    int m_phase;
    int m_lives;
    int m_score;
    int m_over;
    int m_frames_left;
    int m_ball_rst;
    bit m_prev_vsync;

    pong_game_sequencer #(
        .LIVES_INIT  (LIVES_INIT),
        .SCORE_MAX   (SCORE_MAX),
        .SERVE_FRAMES(SERVE_FRAMES),
        .MISS_FRAMES (MISS_FRAMES)
    ) dut (
        .Clock       (clk),
        .Reset       (rst),
        .VGA_VSYNC   (vsync),
        .Start_pushed(start),
        .Hit_pulse   (hit),
        .Miss_pulse  (miss),
        .Move_enable (move_en),
        .Bar_enable  (bar_en),
        .Ball_reset  (ball_rst),
        .Lives       (lives),
        .Score       (score),
        .Game_over   (over),
        .State       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic begin_serve();
        m_phase       = 1;
        m_lives       = LIVES_INIT;
        m_score       = 0;
        m_over        = 0;
        m_frames_left = SERVE_FRAMES;
        m_ball_rst    = 1;
    endtask

    task automatic step(input bit r, input bit vs, input bit st, input bit h, input bit m);
        bit fe;
        @(negedge clk);
        rst   = r;
        vsync = vs;
        start = st;
        hit   = h;
        miss  = m;
        #1;
        fe = m_prev_vsync && !vs;
        chk("move_enable", 8'(move_en), 8'(fe && !r && m_phase == 2));
        chk("bar_enable", 8'(bar_en), 8'(fe && !r && (m_phase == 1 || m_phase == 2)));
        if (move_en) n_move++;
        if (bar_en) n_bar++;
        @(posedge clk);
        m_ball_rst = 0;
        if (r) begin
            m_phase       = 0;
            m_lives       = LIVES_INIT;
            m_score       = 0;
            m_over        = 0;
            m_frames_left = 0;
            m_prev_vsync  = 1'b1;
        end else begin
            m_prev_vsync = vs;
            if (m_phase == 0 || m_phase == 4) begin
                if (st) begin_serve();
            end else if (m_phase == 1) begin
                if (fe) begin
                    m_frames_left--;
                    if (m_frames_left == 0) m_phase = 2;
                end
            end else if (m_phase == 2) begin
                if (m) begin
                    if (m_lives > 1) begin
                        m_lives--;
                        m_phase       = 3;
                        m_frames_left = MISS_FRAMES;
                    end else begin
                        m_lives = 0;
                        m_over  = 1;
                        m_phase = 4;
                    end
                end else if (h) begin
                    m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
                end
            end else if (m_phase == 3) begin
                if (fe) begin
                    m_frames_left--;
                    if (m_frames_left == 0) begin
                        m_phase       = 1;
                        m_frames_left = SERVE_FRAMES;
                        m_ball_rst    = 1;
                    end
                end
            end
        end
        #1;
        chk("state", 8'(state), 8'(m_phase));
        chk("lives", 8'(lives), 8'(m_lives));
        chk("score", 8'(score), 8'(m_score));
        chk("game_over", 8'(over), 8'(m_over));
        chk("ball_reset", 8'(ball_rst), 8'(m_ball_rst));
        if (ball_rst) n_ballr++;
    endtask

    // One VGA frame: vsync low for the first two cycles; directed pulses land on cycle 3.
    task automatic frame(input int len, input bit h, input bit m, input bit st,
                         input int ph = 0, input int pm = 0, input int ps = 0, input int pr = 0);
        for (int i = 0; i < len; i++) begin
            bit rh, rm, rs, rr;
            rh = (h && i == 3) || ($urandom_range(999) < ph);
            rm = (m && i == 3) || ($urandom_range(999) < pm);
            rs = (st && i == 3) || ($urandom_range(999) < ps);
            rr = ($urandom_range(999) < pr);
            step(rr, (i >= 2), rs, rh, rm);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(6, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int base;
        rst = 1'b1; vsync = 1'b1; start = 1'b0; hit = 1'b0; miss = 1'b0;
        m_prev_vsync = 1'b1;
        m_phase = 0; m_lives = LIVES_INIT; m_score = 0; m_over = 0;
        m_frames_left = 0; m_ball_rst = 0;

        // Reset with VSYNC toggling
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_lives", 8'(lives), 8'd3);
        chk("rst_score", 8'(score), 8'd0);
        chk("rst_over", 8'(over), 8'd0);
        chk("rst_no_move", 8'(n_move), 8'd0);

        // Start and serve delay
        step(0, 1, 1, 0, 0);
        chk("start_ball_reset", 8'(ball_rst), 8'd1);
        chk("start_state", 8'(state), 8'd1);
        n_bar = 0; n_move = 0;
        frames(SERVE_FRAMES - 1);
        chk("serve_hold", 8'(state), 8'd1);
        frames(1);
        chk("serve_to_play", 8'(state), 8'd2);
        chk("serve_bar_count", 8'(n_bar), 8'(SERVE_FRAMES));
        chk("serve_no_move", 8'(n_move), 8'd0);
        frames(1);
        chk("first_move", 8'(n_move), 8'd1);

        // Score saturation, one move per frame
        n_move = 0;
        for (int i = 0; i < 17; i++) frame(7, 1'b1, 1'b0, 1'b0);
        chk("score_sat", 8'(score), 8'd15);
        chk("move_per_frame", 8'(n_move), 8'd17);

        // Miss, pause, re-serve
        frame(6, 1'b0, 1'b1, 1'b0);
        chk("miss_lives", 8'(lives), 8'd2);
        chk("miss_state", 8'(state), 8'd3);
        base = n_ballr;
        frames(MISS_FRAMES - 1);
        chk("miss_hold", 8'(state), 8'd3);
        frames(1);
        chk("miss_reserve", 8'(state), 8'd1);
        chk("miss_ball_reset", 8'(n_ballr - base), 8'd1);
        frames(SERVE_FRAMES);

        // Simultaneous hit and miss
        frame(6, 1'b1, 1'b1, 1'b0);
        chk("hitmiss_score", 8'(score), 8'd15);
        chk("hitmiss_lives", 8'(lives), 8'd1);
        frames(MISS_FRAMES + SERVE_FRAMES);

        // Last life lost
        frame(6, 1'b0, 1'b1, 1'b0);
        chk("over_state", 8'(state), 8'd4);
        chk("over_flag", 8'(over), 8'd1);
        chk("over_lives", 8'(lives), 8'd0);
        frame(6, 1'b1, 1'b0, 1'b0);
        frame(6, 1'b0, 1'b1, 1'b0);
        chk("over_ignore", 8'(score), 8'd15);
        frame(6, 1'b0, 1'b0, 1'b1);
        chk("restart_state", 8'(state), 8'd1);
        chk("restart_score", 8'(score), 8'd0);
        chk("restart_lives", 8'(lives), 8'd3);
        chk("restart_over", 8'(over), 8'd0);

        // Reset during play with Score=7
        frames(SERVE_FRAMES);
        for (int i = 0; i < 7; i++) frame(6, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_score", 8'(score), 8'd7);
        n_move = 0;
        base = n_ballr;
        step(1, 0, 0, 0, 0);
        chk("midrst_state", 8'(state), 8'd0);
        chk("midrst_score", 8'(score), 8'd0);
        chk("midrst_lives", 8'(lives), 8'd3);
        chk("midrst_no_pulse", 8'(n_move + n_ballr - base), 8'd0);
        step(0, 1, 0, 0, 0);

        // Random frames against the model
        for (int i = 0; i < 300; i++) begin
            frame(int'($urandom_range(12, 5)), 1'b0, 1'b0, 1'b0, 150, 25, 8, 2);
        end
        frames(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
